div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 96 +++++++++
 tb/tb_div_iter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, signed/unsigned; DIV_FAST_SPECIAL_EN enables the divide-by-zero/overflow fast path
module div_iter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_flush,
  input  logic         i_x_sign,
  input  logic         i_y_sign,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic         o_busy,
  output logic         o_valid,
  output logic [W-1:0] o_quot,
  output logic [W-1:0] o_rem
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  state_t r_state, w_next;
  logic [W-1:0] r_x, r_y, r_ymag, r_q, r_acc, r_quot, r_rem;
  logic r_xs, r_ys;
  logic [$clog2(W)-1:0] r_cnt;
  logic w_xneg_in, w_yneg_in, w_xneg, w_yneg, w_yzero, w_ovf, w_ge;
  logic [W-1:0] w_xmag, w_ymag, w_fq, w_fr;
  logic [W:0] w_sh, w_diff;
  assign w_xneg_in = i_x_sign & i_x[W-1];
  assign w_yneg_in = i_y_sign & i_y[W-1];
  assign w_xmag = w_xneg_in ? -i_x : i_x;
  assign w_ymag = w_yneg_in ? -i_y : i_y;
  assign w_xneg = r_xs & r_x[W-1];
  assign w_yneg = r_ys & r_y[W-1];
  assign w_yzero = r_y == '0;
  assign w_ovf = r_xs & r_ys & (r_x == MIN_NEG) & (r_y == '1);
  assign w_sh = {r_acc, r_q[W-1]};
  assign w_diff = w_sh - {1'b0, r_ymag};
  assign w_ge = !w_diff[W];
  assign w_fq = w_yzero ? '1 : w_ovf ? r_x : (w_xneg ^ w_yneg) ? -r_q : r_q;
  assign w_fr = w_yzero ? r_x : w_ovf ? '0 : w_xneg ? -r_acc : r_acc;
  assign o_quot = r_quot;
  assign o_rem = r_rem;
  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next-state and status outputs; flush always returns to IDLE
  always_comb begin
    w_next = r_state;
    o_busy = r_state != IDLE;
    o_valid = r_state == DONE;
    if (i_flush) w_next = IDLE;
    else
      case (r_state)
        IDLE: if (i_start)
`ifdef DIV_FAST_SPECIAL_EN
          w_next = ((i_y == '0) | (i_x_sign & i_y_sign & (i_x == MIN_NEG) & (i_y == '1))) ? FIX : CALC;
`else
          w_next = CALC;
`endif
        CALC: w_next = (r_cnt == '0) ? FIX : CALC;
        FIX:  w_next = DONE;
        default: w_next = IDLE;
      endcase
  end
  // operand capture, one quotient bit per CALC cycle, sign fix-up into result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_quot <= '0;
      r_rem <= '0;
    end else if (!i_flush)
      case (r_state)
        IDLE: if (i_start) begin
          r_x <= i_x;
          r_y <= i_y;
          r_xs <= i_x_sign;
          r_ys <= i_y_sign;
          r_q <= w_xmag;
          r_ymag <= w_ymag;
          r_acc <= '0;
          r_cnt <= $clog2(W)'(W - 1);
        end
        CALC: begin
          r_acc <= w_ge ? w_diff[W-1:0] : w_sh[W-1:0];
          r_q <= {r_q[W-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_quot <= w_fq;
          r_rem <= w_fr;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and random checks of div_iter against an arithmetic reference model
module tb_div_iter;
  logic i_clk = 0, i_rst = 1, i_start = 0, i_flush = 0, i_x_sign = 0, i_y_sign = 0;
  logic [31:0] i_x = 0, i_y = 0;
  logic o_busy, o_valid;
  logic [31:0] o_quot, o_rem;
  int tests = 0, fails = 0;
  always #5 i_clk = ~i_clk;
  div_iter #(.W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_flush(i_flush),
    .i_x_sign(i_x_sign), .i_y_sign(i_y_sign), .i_x(i_x), .i_y(i_y),
    .o_busy(o_busy), .o_valid(o_valid), .o_quot(o_quot), .o_rem(o_rem)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic bit is_special(input bit xs, input bit ys, input logic [31:0] x, input logic [31:0] y);
    return y == 0 || (xs && ys && x == 32'h80000000 && y == 32'hFFFFFFFF);
  endfunction
  function automatic void model(input bit xs, input bit ys, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r);
    longint xv, yv;
    if (y == 0) begin q = '1; r = x; end
    else if (is_special(xs, ys, x, y)) begin q = x; r = 0; end
    else begin
      xv = xs ? longint'($signed(x)) : longint'({32'b0, x});
      yv = ys ? longint'($signed(y)) : longint'({32'b0, y});
      q = 32'(xv / yv);
      r = 32'(xv % yv);
    end
  endfunction
  // starts in the current (IDLE) cycle N, returns in cycle after the o_valid pulse
  task automatic do_op(input string tag, input bit xs, input bit ys, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eq, er;
    int lat, vk;
    bit busy_ok;
    model(xs, ys, x, y, eq, er);
    lat = 34;
`ifdef DIV_FAST_SPECIAL_EN
    if (is_special(xs, ys, x, y)) lat = 2;
`endif
    i_x_sign = xs; i_y_sign = ys; i_x = x; i_y = y; i_start = 1;
    @(posedge i_clk); #1;
    i_start = 0; i_x = $urandom; i_y = $urandom; i_x_sign = 1'($urandom); i_y_sign = 1'($urandom);
    chk({tag, ".busy1"}, 32'(o_busy), 32'd1);
    vk = 0; busy_ok = 1;
    for (int k = 1; k <= 40 && vk == 0; k++) begin
      if (!o_busy) busy_ok = 0;
      if (o_valid) vk = k;
      else begin @(posedge i_clk); #1; end
    end
    chk({tag, ".lat"}, 32'(vk), 32'(lat));
    chk({tag, ".busyrun"}, 32'(busy_ok), 32'd1);
    chk({tag, ".q"}, o_quot, eq);
    chk({tag, ".r"}, o_rem, er);
    @(posedge i_clk); #1;
    chk({tag, ".vpulse"}, 32'(o_valid), 32'd0);
    chk({tag, ".idle"}, 32'(o_busy), 32'd0);
    chk({tag, ".qhold"}, o_quot, eq);
  endtask
  initial begin
    logic [31:0] q0, x, y;
    bit seen;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.busy", 32'(o_busy), 0);
    chk("rst.valid", 32'(o_valid), 0);
    chk("rst.q", o_quot, 0);
    chk("rst.r", o_rem, 0);
    i_rst = 0;
    @(posedge i_clk); #1;
    do_op("neg7div2", 1, 1, 32'hFFFFFFF9, 32'd2);
    do_op("udiv16", 0, 0, 32'hFFFFFFFF, 32'h10);
    do_op("div0s", 1, 1, 32'h12345678, 0);
    do_op("div0u", 0, 0, 32'h12345678, 0);
    do_op("div0neg", 1, 1, 32'h87654321, 0);
    do_op("ovf", 1, 1, 32'h80000000, 32'hFFFFFFFF);
    do_op("ovfu", 0, 0, 32'h80000000, 32'hFFFFFFFF);
    do_op("mix", 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("ysmall", 1, 0, 32'h80000001, 32'd3);
    for (int i = 0; i < 20; i++) begin
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) y = -y;
      do_op($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), x, y);
    end
    q0 = o_quot;
    i_x = 1000; i_y = 3; i_x_sign = 0; i_y_sign = 0; i_start = 1;
    @(posedge i_clk); #1;
    i_start = 0;
    repeat (9) begin @(posedge i_clk); #1; end
    i_flush = 1;
    @(posedge i_clk); #1;
    i_flush = 0;
    chk("flush.busy", 32'(o_busy), 0);
    chk("flush.valid", 32'(o_valid), 0);
    chk("flush.q", o_quot, q0);
    @(posedge i_clk); #1;
    do_op("after_flush", 0, 0, 32'd100, 32'd7);
    i_start = 1; i_flush = 1; i_x = 50; i_y = 5;
    @(posedge i_clk); #1;
    i_start = 0; i_flush = 0;
    chk("flush_wins", 32'(o_busy), 0);
    i_start = 1;
    @(posedge i_clk); #1;
    i_start = 0;
    repeat (4) begin @(posedge i_clk); #1; end
    i_rst = 1;
    @(posedge i_clk); #1;
    i_rst = 0;
    chk("midrst.busy", 32'(o_busy), 0);
    chk("midrst.valid", 32'(o_valid), 0);
    chk("midrst.q", o_quot, 0);
    chk("midrst.r", o_rem, 0);
    seen = 0;
    repeat (40) begin
      @(posedge i_clk); #1;
      if (o_valid) seen = 1;
    end
    chk("midrst.novalid", 32'(seen), 0);
    do_op("post_rst", 1, 0, 32'hFFFFFF00, 32'd16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
